// File: rtl/i2s_pkg.sv
// ------------------------------------------------------------------
// i2s_pkg : shared types and constants for the I2S receive path
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package i2s_pkg;

   localparam int SYNC_STAGES = 2;
   localparam int PAIR_WIDTH  = 16;

   typedef struct packed {
      logic [PAIR_WIDTH-1:0] left;
      logic [PAIR_WIDTH-1:0] right;
   } i2s_pair_t;

endpackage

`default_nettype wire

// File: rtl/i2s_rx_stream_if.sv
// ------------------------------------------------------------------
// i2s_rx_stream_if : Avalon-ST link carrying {left,right} sample pairs
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

interface i2s_rx_stream_if #(
   parameter int WIDTH = 16
);

   logic [2*WIDTH-1:0] st_data;
   logic               st_valid;
   logic               st_ready;

   modport master (output st_data, output st_valid, input  st_ready);
   modport slave  (input  st_data, input  st_valid, output st_ready);

endinterface

`default_nettype wire

// File: rtl/i2s_pulse_sync.sv
// ------------------------------------------------------------------
// i2s_pulse_sync : sck-to-clk level synchroniser with registered rising-edge pulse
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module i2s_pulse_sync
   import i2s_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic pulse_out
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              edge_q, edge_d;
   logic              pulse_q, pulse_d;

   always_comb begin
      sync_d  = {sync_q[STAGES-2:0], async_in};
      edge_d  = sync_q[STAGES-1];
      // one pulse per rising edge, however long the source level is held
      pulse_d = sync_q[STAGES-1] & ~edge_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         edge_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         edge_q  <= edge_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_out = pulse_q;

endmodule

`default_nettype wire

// File: rtl/i2s_rx_stream.sv
// ------------------------------------------------------------------
// i2s_rx_stream : captures I2S sample pairs into a show-ahead FIFO, Avalon-ST source
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module i2s_rx_stream
   import i2s_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [WIDTH-1:0]         i2s_data_left,
   input  logic [WIDTH-1:0]         i2s_data_right,
   input  logic                     i2s_sample_ready,
   i2s_rx_stream_if.master          st,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [CNT_W-1:0]         overflow_count,
   input  logic                     overflow_clear
);

   localparam int                PTR_W  = $clog2(DEPTH);
   localparam int                FILL_W = PTR_W + 1;
   localparam logic [FILL_W-1:0] C_FULL = FILL_W'(DEPTH);

   logic                 cap_strobe;
   logic                 push, pop, drop;
   logic [2*WIDTH-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [CNT_W-1:0]     ovf_q, ovf_d;

   i2s_pulse_sync #(.STAGES(SYNC_STAGES)) u_strobe_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .async_in  (i2s_sample_ready),
      .pulse_out (cap_strobe)
   );

   always_comb begin
      pop      = (fill_q != '0) && st.st_ready;
      // a full FIFO still accepts when the head leaves in the same cycle
      push     = cap_strobe && enable && ((fill_q != C_FULL) || pop);
      drop     = cap_strobe && enable && !push;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
      if (overflow_clear)
         ovf_d = CNT_W'(drop);
      else if (drop && !(&ovf_q))
         ovf_d = ovf_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         ovf_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         ovf_q    <= ovf_d;
      end
   end

   // sample data is quasi-static for many sck cycles after the strobe
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {i2s_data_left, i2s_data_right};
   end

   assign st.st_valid    = (fill_q != '0);
   assign st.st_data     = st.st_valid ? mem_q[rd_ptr_q] : '0;
   assign fill_level     = fill_q;
   assign overflow_count = ovf_q;

endmodule

`default_nettype wire
